nioslab2_ram_ctrl: RTL and testbench
====================================

NIOSLAB2_RAM_CTRL -- requirements
Module: niosLab2_ram_ctrl

Interface
REQ-001 SHALL have parameter MAX_BURST, default 8: largest burst length accepted (1..15).
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port s_address, input, 10: word address of the first beat.
REQ-005 SHALL have port s_read, input, 1: read request.
REQ-006 SHALL have port s_write, input, 1: write request or write beat.
REQ-007 SHALL have port s_byteenable, input, 4: byte lanes for the write beat.
REQ-008 SHALL have port s_writedata, input, 32: write beat data.
REQ-009 SHALL have port s_burstcount, input, 4: beats in the transaction; sampled only on the first beat.
REQ-010 SHALL have port s_waitrequest, output, 1: request not accepted this cycle.
REQ-011 SHALL have port s_readdata, output, 32: read beat data.
REQ-012 SHALL have port s_readdatavalid, output, 1: s_readdata is valid this cycle.
REQ-013 SHALL have ports ram_address (10), ram_byteenable (4), ram_chipselect (1), ram_write (1), ram_writedata (32), ram_clken (1), all outputs: drive the single-port RAM.
REQ-014 SHALL have port ram_readdata, input, 32: RAM output; valid one cycle after its address is presented.

Function
REQ-015 SHALL implement states IDLE, RBURST, WBURST, with a 10-bit address counter and a 4-bit beat counter.
REQ-016 SHALL tie ram_clken to 1 and pass s_readdata = ram_readdata combinationally.
REQ-017 In IDLE, s_waitrequest SHALL be 0, and the RAM outputs SHALL follow s_address/s_byteenable/s_writedata combinationally.
REQ-018 In IDLE with s_write=1, the controller SHALL assert ram_chipselect=ram_write=1 (first beat); if count>1 it SHALL load addr=s_address+1 and remaining=count-1, then enter WBURST.
REQ-019 In IDLE with s_read=1, the controller SHALL assert ram_chipselect=1 and ram_write=0, and SHALL assert s_readdatavalid in the following cycle; if count>1 it SHALL load the counters as in REQ-018, then enter RBURST.
REQ-020 In RBURST, s_waitrequest SHALL be 1, the controller SHALL present addr with ram_chipselect=1 every cycle and increment addr, and SHALL return to IDLE after the last address; s_readdatavalid SHALL be high for exactly N consecutive cycles, starting the cycle after acceptance.
REQ-021 In WBURST, s_waitrequest SHALL be 0; each cycle with s_write=1 SHALL write s_writedata/s_byteenable to addr, then increment addr and decrement remaining; a cycle with s_write=0 SHALL write nothing and hold the counters; after the last beat the controller SHALL return to IDLE.
REQ-022 Addresses SHALL wrap modulo 1024 (0x3FF+1 -> 0x000).
REQ-023 s_burstcount=0 SHALL be treated as 1; s_burstcount>MAX_BURST SHALL be clamped to MAX_BURST.
REQ-024 If s_read and s_write are both high in IDLE, the write SHALL take priority, and the read SHALL be dropped with no readdatavalid.
REQ-025 s_read SHALL be ignored in WBURST, and s_write SHALL be ignored in RBURST.

Reset
REQ-026 While reset is high: state=IDLE, counters=0, s_readdatavalid=0, ram_write=0, ram_chipselect=0, s_waitrequest=1.
REQ-027 A reset during a burst SHALL abort it immediately; no further readdatavalid or write SHALL occur after reset releases.

Configuration
REQ-028 With macro NIOSLAB2_RAM_CTRL_BURST_EN defined, REQ-018..REQ-023 burst behaviour SHALL apply; when it is undefined, s_burstcount SHALL be ignored, every transaction SHALL be single-beat, and RBURST/WBURST SHALL NOT be synthesized.

Verification
REQ-029 Single write 0x0A5=0xDEADBEEF with be=0xF, then single read 0x0A5 -> readdatavalid one cycle after acceptance, data 0xDEADBEEF.
REQ-030 Write burst of 4 starting at 0x3FE with data 1,2,3,4, with s_write low for one cycle mid-burst -> RAM 0x3FE=1, 0x3FF=2, 0x000=3, 0x001=4; no write in the gap cycle.
REQ-031 Read burst of 4 at 0x3FE -> waitrequest high 3 cycles, readdatavalid 4 consecutive cycles, data 1,2,3,4.
REQ-032 Partial write be=0x2, data 0x0000AB00 over 0x11223344 -> read back 0x1122AB44.
REQ-033 Reset asserted on the 2nd cycle of an 8-beat read -> readdatavalid 0 from the cycle of the reset onward; the next single read completes normally.
REQ-034 s_burstcount=0 and s_burstcount=15 (MAX_BURST=8) -> 1 and 8 readdatavalid pulses respectively; with NIOSLAB2_RAM_CTRL_BURST_EN undefined -> 1 pulse each.

Source files
------------

// File: rtl/nioslab2_ram_ctrl.sv
// Avalon-MM slave front end for a single-port RAM with one-cycle read latency.
// Define NIOSLAB2_RAM_CTRL_BURST_EN to enable multi-beat bursts; otherwise every transaction is one beat.
module nioslab2_ram_ctrl #(
    parameter int MAX_BURST = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  s_address,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [3:0]  s_byteenable,
    input  logic [31:0] s_writedata,
    input  logic [3:0]  s_burstcount,
    output logic        s_waitrequest,
    output logic [31:0] s_readdata,
    output logic        s_readdatavalid,
    output logic [9:0]  ram_address,
    output logic [3:0]  ram_byteenable,
    output logic        ram_chipselect,
    output logic        ram_write,
    output logic [31:0] ram_writedata,
    output logic        ram_clken,
    input  logic [31:0] ram_readdata
);

    logic rd_issue;
    logic vld_p1;

    assign ram_clken       = 1'b1;
    assign s_readdata      = ram_readdata;
    assign s_readdatavalid = vld_p1;

`ifdef NIOSLAB2_RAM_CTRL_BURST_EN
    typedef enum logic [1:0] {IDLE, RBURST, WBURST} state_t;

    state_t     state, state_nxt;
    logic [9:0] addr_q;
    logic [3:0] remain_q;
    logic [3:0] first_cnt;

    // Zero-length requests become single beats; oversize requests saturate.
    function automatic logic [3:0] clamp_count(input logic [3:0] bc);
        if (bc == 4'd0)
            return 4'd1;
        else if (bc > 4'(MAX_BURST))
            return 4'(MAX_BURST);
        else
            return bc;
    endfunction

    assign first_cnt = clamp_count(s_burstcount);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (s_write) begin
                    if (first_cnt > 4'd1) state_nxt = WBURST;
                end else if (s_read) begin
                    if (first_cnt > 4'd1) state_nxt = RBURST;
                end
            end
            RBURST:  if (remain_q == 4'd1) state_nxt = IDLE;
            WBURST:  if (s_write && remain_q == 4'd1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // First beat is served from s_address, so the counters start one beat ahead.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q   <= '0;
            remain_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if ((s_write || s_read) && first_cnt > 4'd1) begin
                        addr_q   <= s_address + 10'd1;
                        remain_q <= first_cnt - 4'd1;
                    end
                end
                RBURST: begin
                    addr_q   <= addr_q + 10'd1;
                    remain_q <= remain_q - 4'd1;
                end
                WBURST: begin
                    if (s_write) begin
                        addr_q   <= addr_q + 10'd1;
                        remain_q <= remain_q - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        s_waitrequest  = 1'b0;
        ram_address    = s_address;
        ram_byteenable = s_byteenable;
        ram_writedata  = s_writedata;
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        rd_issue       = 1'b0;
        if (reset) begin
            s_waitrequest = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    ram_chipselect = s_read | s_write;
                    ram_write      = s_write;
                    rd_issue       = s_read & ~s_write;
                end
                RBURST: begin
                    s_waitrequest  = 1'b1;
                    ram_address    = addr_q;
                    ram_chipselect = 1'b1;
                    rd_issue       = 1'b1;
                end
                WBURST: begin
                    ram_address    = addr_q;
                    ram_chipselect = s_write;
                    ram_write      = s_write;
                end
                default: s_waitrequest = 1'b1;
            endcase
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^{s_burstcount, 4'(MAX_BURST)};

    always_comb begin
        s_waitrequest  = reset;
        ram_address    = s_address;
        ram_byteenable = s_byteenable;
        ram_writedata  = s_writedata;
        ram_chipselect = ~reset & (s_read | s_write);
        ram_write      = ~reset & s_write;
        rd_issue       = ~reset & s_read & ~s_write;
    end
`endif

    // p1: read data returns one cycle after the RAM sees its address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= rd_issue;
    end

endmodule

// File: tb/tb_nioslab2_ram_ctrl.sv
// Scoreboard bench for nioslab2_ram_ctrl with a behavioural single-port RAM attached.
// Expectations follow NIOSLAB2_RAM_CTRL_BURST_EN the same way the design build does.
module tb_nioslab2_ram_ctrl;

`ifdef NIOSLAB2_RAM_CTRL_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  s_address;
    logic        s_read;
    logic        s_write;
    logic [3:0]  s_byteenable;
    logic [31:0] s_writedata;
    logic [3:0]  s_burstcount;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic        s_readdatavalid;
    logic [9:0]  ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect;
    logic        ram_write;
    logic [31:0] ram_writedata;
    logic        ram_clken;
    logic [31:0] ram_readdata;

    logic        ram_clr;
    logic [31:0] ram_sim [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] exp_q [$];
    int          total = 0;
    int          bad = 0;

    nioslab2_ram_ctrl #(.MAX_BURST(8)) dut (
        .clk(clk), .reset(reset),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_byteenable(s_byteenable), .s_writedata(s_writedata), .s_burstcount(s_burstcount),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable), .ram_chipselect(ram_chipselect),
        .ram_write(ram_write), .ram_writedata(ram_writedata), .ram_clken(ram_clken),
        .ram_readdata(ram_readdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 1024; i++) ram_sim[i] <= '0;
        end else if (ram_chipselect && ram_clken) begin
            if (ram_write)
                for (int k = 0; k < 4; k++)
                    if (ram_byteenable[k]) ram_sim[ram_address][8*k +: 8] <= ram_writedata[8*k +: 8];
            ram_readdata <= ram_sim[ram_address];
        end
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = d[8*k +: 8];
        return r;
    endfunction

    task automatic idle_inputs();
        s_read = 1'b0; s_write = 1'b0; s_address = '0;
        s_byteenable = 4'hF; s_writedata = '0; s_burstcount = 4'd1;
    endtask

    task automatic do_write(input logic [9:0] a, input logic [3:0] be, input logic [31:0] d, input string nm);
        s_write = 1'b1; s_address = a; s_byteenable = be; s_writedata = d; s_burstcount = 4'd1;
        @(negedge clk);
        total++;
        if ({s_waitrequest, ram_chipselect, ram_write} !== 3'b011) begin
            bad++;
            $display("FAIL %s: wait/cs/we=%b want 011", nm, {s_waitrequest, ram_chipselect, ram_write});
        end
        @(posedge clk); #1;
        s_write = 1'b0;
        ref_mem[a] = merge(ref_mem[a], d, be);
    endtask

    // Issues one read command, watches n+2 cycles, pops the scoreboard on every valid beat.
    task automatic do_read(input logic [9:0] a, input logic [3:0] bc, input int n, input bit junk_wr, input string nm);
        logic [31:0] vpat, wpat, e;
        logic [9:0]  ai;
        vpat = '0; wpat = '0;
        for (int i = 0; i < n; i++) begin
            ai = a + 10'(i);
            exp_q.push_back(ref_mem[ai]);
        end
        s_read = 1'b1; s_address = a; s_burstcount = bc;
        @(negedge clk);
        total++;
        if (s_waitrequest !== 1'b0) begin
            bad++;
            $display("FAIL %s_accept: waitrequest=%b want 0", nm, s_waitrequest);
        end
        @(posedge clk); #1;
        s_read = 1'b0;
        s_write = junk_wr && (n > 1); s_writedata = 32'hBADBAD00; s_byteenable = 4'hF;
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            vpat[i] = s_readdatavalid;
            wpat[i] = s_waitrequest;
            if (s_readdatavalid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL %s_unexpected_valid: readdata=%h with nothing outstanding", nm, s_readdata);
                end else begin
                    e = exp_q.pop_front();
                    if (s_readdata !== e) begin
                        bad++;
                        $display("FAIL %s_data: beat %0d readdata=%h want %h", nm, i, s_readdata, e);
                    end
                end
            end
            @(posedge clk); #1;
            s_write = junk_wr && (i + 1 < n - 1);
        end
        s_write = 1'b0;
        total++;
        if (vpat !== 32'((64'd1 << n) - 1)) begin
            bad++;
            $display("FAIL %s_valid_pattern: got %b want %b", nm, vpat, 32'((64'd1 << n) - 1));
        end
        total++;
        if (wpat !== 32'((64'd1 << (n - 1)) - 1)) begin
            bad++;
            $display("FAIL %s_wait_pattern: got %b want %b", nm, wpat, 32'((64'd1 << (n - 1)) - 1));
        end
    endtask

    task automatic test_reset();
        s_read = 1'b1; s_write = 1'b1;
        @(negedge clk);
        total++;
        if ({s_waitrequest, ram_chipselect, ram_write, s_readdatavalid} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_outputs: wait/cs/we/vld=%b want 1000",
                     {s_waitrequest, ram_chipselect, ram_write, s_readdatavalid});
        end
        total++;
        if (ram_clken !== 1'b1) begin
            bad++;
            $display("FAIL reset_clken: got %b want 1", ram_clken);
        end
        idle_inputs();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (s_waitrequest !== 1'b0) begin
            bad++;
            $display("FAIL idle_wait: got %b want 0", s_waitrequest);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        do_write(10'h0A5, 4'hF, 32'hDEADBEEF, "single_wr");
        do_read(10'h0A5, 4'd1, 1, 1'b0, "single_rd");
    endtask

    task automatic test_write_burst_gap();
        logic [9:0] wa;
        for (int b = 0; b < 4; b++) begin
            if (b == 2) begin
                s_write = 1'b0; s_writedata = 32'hFFFF_FFFF;
                @(negedge clk);
                total++;
                if ({ram_chipselect, ram_write} !== 2'b00) begin
                    bad++;
                    $display("FAIL wburst_gap: cs/we=%b want 00", {ram_chipselect, ram_write});
                end
                @(posedge clk); #1;
            end
            s_write = 1'b1; s_address = 10'h3FE; s_byteenable = 4'hF;
            s_writedata = 32'(b + 1); s_burstcount = 4'd4;
            @(negedge clk);
            total++;
            if ({s_waitrequest, ram_write} !== 2'b01) begin
                bad++;
                $display("FAIL wburst_beat%0d: wait/we=%b want 01", b, {s_waitrequest, ram_write});
            end
            @(posedge clk); #1;
            wa = BURST ? 10'h3FE + 10'(b) : 10'h3FE;
            ref_mem[wa] = 32'(b + 1);
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) do_read(10'h3FE + 10'(i), 4'd1, 1, 1'b0, "wburst_readback");
    endtask

    task automatic test_read_burst();
        do_read(10'h3FE, 4'd4, BURST ? 4 : 1, BURST, "rburst");
        for (int i = 0; i < 4; i++) do_read(10'h3FE + 10'(i), 4'd1, 1, 1'b0, "rburst_nowrite");
    endtask

    task automatic test_partial();
        do_write(10'h040, 4'hF, 32'h11223344, "partial_full");
        do_write(10'h040, 4'h2, 32'h0000AB00, "partial_lane");
        do_read(10'h040, 4'd1, 1, 1'b0, "partial_rd");
    endtask

    task automatic test_rw_priority();
        logic [3:0] vpat;
        vpat = '0;
        s_read = 1'b1; s_write = 1'b1; s_address = 10'h155;
        s_byteenable = 4'hF; s_writedata = 32'hCAFEF00D; s_burstcount = 4'd1;
        @(negedge clk);
        total++;
        if (ram_write !== 1'b1) begin
            bad++;
            $display("FAIL rw_priority_we: got %b want 1", ram_write);
        end
        @(posedge clk); #1;
        idle_inputs();
        ref_mem[10'h155] = 32'hCAFEF00D;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); vpat[i] = s_readdatavalid;
            @(posedge clk); #1;
        end
        total++;
        if (vpat !== 4'b0000) begin
            bad++;
            $display("FAIL rw_priority_valid: got %b want 0000", vpat);
        end
        do_read(10'h155, 4'd1, 1, 1'b0, "rw_priority_rd");
    endtask

    task automatic test_read_ignored_in_wburst();
        logic [5:0] vpat;
        logic [9:0] wa;
        vpat = '0;
        for (int b = 0; b < 3; b++) begin
            s_write = 1'b1; s_read = 1'b1; s_address = 10'h200; s_byteenable = 4'hF;
            s_writedata = 32'hA0 + 32'(b); s_burstcount = 4'd3;
            @(negedge clk); vpat[b] = s_readdatavalid;
            @(posedge clk); #1;
            wa = BURST ? 10'h200 + 10'(b) : 10'h200;
            ref_mem[wa] = 32'hA0 + 32'(b);
        end
        idle_inputs();
        for (int i = 3; i < 6; i++) begin
            @(negedge clk); vpat[i] = s_readdatavalid;
            @(posedge clk); #1;
        end
        total++;
        if (vpat !== 6'b000000) begin
            bad++;
            $display("FAIL wburst_read_ignored: valid=%b want 000000", vpat);
        end
        for (int i = 0; i < 3; i++) do_read(10'h200 + 10'(i), 4'd1, 1, 1'b0, "wburst_rd_readback");
    endtask

    task automatic test_burstcount_edge();
        do_read(10'h3FC, 4'd0, 1, 1'b0, "bc_zero");
        do_read(10'h3FC, 4'd15, BURST ? 8 : 1, 1'b0, "bc_clamp");
    endtask

    task automatic test_reset_abort();
        logic [9:0] quiet;
        quiet = '0;
        s_read = 1'b1; s_address = 10'h3FE; s_burstcount = 4'd8;
        @(posedge clk); #1;
        s_read = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({s_readdatavalid, s_waitrequest, ram_chipselect} !== 3'b010) begin
            bad++;
            $display("FAIL abort_in_reset: vld/wait/cs=%b want 010",
                     {s_readdatavalid, s_waitrequest, ram_chipselect});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); quiet[i] = s_readdatavalid | ram_write;
            @(posedge clk); #1;
        end
        total++;
        if (quiet !== 10'd0) begin
            bad++;
            $display("FAIL abort_after_reset: vld|we=%b want 0", quiet);
        end
        do_read(10'h040, 4'd1, 1, 1'b0, "abort_next_rd");
    endtask

    initial begin
        reset = 1'b1;
        ram_clr = 1'b1;
        idle_inputs();
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        ram_clr = 1'b0;
        test_reset();
        test_single();
        test_write_burst_gap();
        test_read_burst();
        test_partial();
        test_rw_priority();
        test_read_ignored_in_wburst();
        test_burstcount_edge();
        test_reset_abort();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d beats outstanding want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
